// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiters: default sizes, the index-width
// helper and the burst-lock state encoding.
package fifo_arb_pkg;

  // Defaults shared with the fifo instance the arbiter feeds.
  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultNumReq   = 4;
  localparam int unsigned DefaultMaxBurst = 4;

  // Burst-lock states (only used when FIFO_ARB_BURST_LOCK_EN is defined).
  typedef enum logic {
    StOpen,
    StLocked
  } burst_state_e;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set bit of req_i, searching from ptr_i
// upwards with wrap-around. Returns one-hot grant, its index and an any-valid flag.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = DefaultNumReq,
  parameter int unsigned IdxW   = clog2_min1(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  // Walk the requesters in priority order and keep the first hit.
  always_comb begin
    int unsigned j;
    logic [IdxW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j  = (32'(ptr_i) + k) % NumReq;
      jj = IdxW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers. A single
// registered output stage drives the fifo, so fifo_write_valid/fifo_in_data are flops.
// Optional macro FIFO_ARB_BURST_LOCK_EN: the winner keeps the port for up to MAX_BURST
// consecutive words while it stays valid.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefaultNumReq,
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MAX_BURST = DefaultMaxBurst
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_write_valid,
  input  logic [NUM_REQ*WIDTH-1:0]          req_in_data,
  output logic [NUM_REQ-1:0]                req_write_ready,
  output logic                              fifo_write_valid,
  output logic [WIDTH-1:0]                  fifo_in_data,
  input  logic                              fifo_write_ready,
  output logic [clog2_min1(NUM_REQ)-1:0]    last_grant,
  output logic                              busy
);

  localparam int unsigned IdxW = clog2_min1(NUM_REQ);

  // Next index with wrap-around.
  function automatic logic [IdxW-1:0] inc_mod(input logic [IdxW-1:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [IdxW-1:0]      last_grant_q, last_grant_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;

  logic                 can_accept;
  logic                 transfer;
  logic [IdxW-1:0]      pick_ptr;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic [WIDTH-1:0]     req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = req_in_data[i*WIDTH +: WIDTH];
  end

  rr_priority_pick #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_pick (
    .req_i  (req_write_valid),
    .ptr_i  (pick_ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // The output stage can take a word if it is empty or being drained this cycle.
  assign can_accept      = !out_valid_q || fifo_write_ready;
  // No accept while reset is held: the word would be lost.
  assign req_write_ready = (can_accept && !rst) ? pick_gnt : '0;
  assign transfer        = can_accept && pick_any && !rst;

  assign fifo_write_valid = out_valid_q;
  assign fifo_in_data     = out_data_q;
  assign busy             = out_valid_q;
  assign last_grant       = last_grant_q;

`ifdef FIFO_ARB_BURST_LOCK_EN

  burst_state_e   state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [7:0]      count_q, count_d;

  // While locked, searching from the owner gives it absolute priority and, if it has
  // dropped valid, falls through to owner+1 onwards, i.e. the rotated priority.
  assign pick_ptr = (state_q == StLocked) ? owner_q : ptr_q;

  // Output stage, pointer and burst-lock next state.
  always_comb begin
    logic [7:0] count_next;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    ptr_d        = ptr_q;
    state_d      = state_q;
    owner_d      = owner_q;
    count_d      = count_q;
    count_next   = 8'd1;

    // Owner gave up while the port was free: release and rotate past it.
    if (state_q == StLocked && can_accept && !req_write_valid[owner_q]) begin
      ptr_d   = inc_mod(owner_q);
      state_d = StOpen;
      count_d = '0;
    end

    if (transfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = req_word[pick_idx];
      last_grant_d = pick_idx;
      count_next   = (state_q == StLocked && pick_idx == owner_q) ? count_q + 8'd1 : 8'd1;
      if (32'(count_next) >= MAX_BURST) begin
        ptr_d   = inc_mod(pick_idx);
        state_d = StOpen;
        count_d = '0;
      end else begin
        state_d = StLocked;
        owner_d = pick_idx;
        count_d = count_next;
      end
    end else if (out_valid_q && fifo_write_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= '0;
      ptr_q        <= '0;
      state_q      <= StOpen;
      owner_q      <= '0;
      count_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
      ptr_q        <= ptr_d;
      state_q      <= state_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
    end
  end

`else

  // MAX_BURST only matters with burst lock enabled.
  logic unused_max_burst;
  assign unused_max_burst = ^MAX_BURST;

  assign pick_ptr = ptr_q;

  // Output stage and pointer next state: pointer moves past each winner.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    ptr_d        = ptr_q;
    if (transfer) begin
      out_valid_d  = 1'b1;
      out_data_d   = req_word[pick_idx];
      last_grant_d = pick_idx;
      ptr_d        = inc_mod(pick_idx);
    end else if (out_valid_q && fifo_write_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      last_grant_q <= '0;
      ptr_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
      ptr_q        <= ptr_d;
    end
  end

`endif

endmodule
